// File: rtl/step_dir_decoder_if.sv
// Signal bundle between a step/dir decoder and its register-file side.
// Limit ports exist only when STEP_DIR_DECODER_POS_LIMIT_EN is defined.
interface step_dir_decoder_if #(
  parameter int POS_WIDTH = 32
);
  logic                 step_in;
  logic                 dir_in;
  logic                 pos_load;
  logic [POS_WIDTH-1:0] pos_load_val;
  logic [POS_WIDTH-1:0] target;
  logic                 clear_flags;
  logic [POS_WIDTH-1:0] position;
  logic                 step_strobe;
  logic                 at_target;
  logic                 moving;
  logic                 dir_err;
  logic [15:0]          glitch_cnt;
`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
  logic [POS_WIDTH-1:0] lim_min;
  logic [POS_WIDTH-1:0] lim_max;
  logic                 limit_hit;

  modport master (
    output step_in, dir_in, pos_load, pos_load_val, target, clear_flags, lim_min, lim_max,
    input  position, step_strobe, at_target, moving, dir_err, glitch_cnt, limit_hit
  );
  modport slave (
    input  step_in, dir_in, pos_load, pos_load_val, target, clear_flags, lim_min, lim_max,
    output position, step_strobe, at_target, moving, dir_err, glitch_cnt, limit_hit
  );
`else
  modport master (
    output step_in, dir_in, pos_load, pos_load_val, target, clear_flags,
    input  position, step_strobe, at_target, moving, dir_err, glitch_cnt
  );
  modport slave (
    input  step_in, dir_in, pos_load, pos_load_val, target, clear_flags,
    output position, step_strobe, at_target, moving, dir_err, glitch_cnt
  );
`endif
endinterface

// File: rtl/step_dir_decoder.sv
// Step/dir receive decoder: synchronizes pins, filters glitches, checks dir setup, tracks signed position.
// Optional clamping to [lim_min, lim_max] when STEP_DIR_DECODER_POS_LIMIT_EN is defined.
module step_dir_decoder #(
  parameter int POS_WIDTH    = 32,
  parameter int MIN_PULSE    = 4,
  parameter int DIR_SETUP    = 2,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input logic               clock,
  input logic               reset,
  step_dir_decoder_if.slave bus
);
  localparam int HW = $clog2(MIN_PULSE + 1);
  localparam int DW = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [HW-1:0] MIN_PULSE_C = HW'(MIN_PULSE);
  localparam logic [DW-1:0] DIR_SETUP_C = DW'(DIR_SETUP);
  localparam logic [IW-1:0] IDLE_C      = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_LOW, S_ARM, S_HIGH} state_t;

  state_t               state_q, state_d;
  logic [1:0]           step_sync_q, dir_sync_q, live_q;
  logic                 s_step, s_dir, dir_prev_q, low_seen_q;
  logic [DW-1:0]        dstab_q, dstab_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic                 dir_ok_q, dir_ok_d;
  logic                 accept, glitch;
  logic                 strobe_q, step_dir_q;
  logic [POS_WIDTH-1:0] pos_q, pos_d, pos_base;
  logic                 at_target_q;
  logic                 moving_q, moving_d;
  logic [IW-1:0]        idle_q, idle_d, idle_inc;
  logic                 dir_err_q, dir_err_d;
  logic [15:0]          glitch_cnt_q, glitch_cnt_d, glitch_base;
  logic                 limit_set;

  assign s_step = step_sync_q[1];
  assign s_dir  = dir_sync_q[1];

  always_comb begin
    dstab_d = dstab_q;
    if (s_dir != dir_prev_q)        dstab_d = '0;
    else if (dstab_q < DIR_SETUP_C) dstab_d = dstab_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    dir_ok_d = dir_ok_q;
    accept   = 1'b0;
    glitch   = 1'b0;
    case (state_q)
      // low_seen_q blocks a pulse that was already high when reset released
      S_LOW: if (s_step && low_seen_q) begin
        hcnt_d   = HW'(1);
        dir_ok_d = (dstab_q >= DIR_SETUP_C);
        if (MIN_PULSE == 1) begin
          accept  = 1'b1;
          state_d = S_HIGH;
        end else begin
          state_d = S_ARM;
        end
      end
      S_ARM: if (s_step) begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_d == MIN_PULSE_C) begin
          accept  = 1'b1;
          state_d = S_HIGH;
        end
      end else begin
        glitch  = 1'b1;
        state_d = S_LOW;
      end
      S_HIGH: if (!s_step) state_d = S_LOW;
      default: state_d = S_LOW;
    endcase
  end

  always_comb begin
    pos_base  = bus.pos_load ? bus.pos_load_val : pos_q;
    pos_d     = pos_base;
    limit_set = 1'b0;
    if (strobe_q) begin
`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
      if (step_dir_q && ($signed(pos_base) >= $signed(bus.lim_max)))
        limit_set = 1'b1;
      else if (!step_dir_q && ($signed(pos_base) <= $signed(bus.lim_min)))
        limit_set = 1'b1;
      else
`endif
      pos_d = step_dir_q ? pos_base + POS_WIDTH'(1) : pos_base - POS_WIDTH'(1);
    end
  end

  always_comb begin
    moving_d = moving_q;
    idle_d   = idle_q;
    idle_inc = idle_q + 1'b1;
    if (strobe_q) begin
      moving_d = 1'b1;
      idle_d   = '0;
    end else if (moving_q) begin
      idle_d = idle_inc;
      if (idle_inc == IDLE_C) begin
        moving_d = 1'b0;
        idle_d   = '0;
      end
    end
  end

  // A new violation or glitch in the clearing cycle still registers
  always_comb begin
    dir_err_d = bus.clear_flags ? 1'b0 : dir_err_q;
    if (accept && !dir_ok_d) dir_err_d = 1'b1;
    glitch_base  = bus.clear_flags ? 16'h0000 : glitch_cnt_q;
    glitch_cnt_d = glitch_base;
    if (glitch && (glitch_base != 16'hFFFF)) glitch_cnt_d = glitch_base + 16'h0001;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_sync_q  <= '0;
      dir_sync_q   <= '0;
      live_q       <= '0;
      dir_prev_q   <= 1'b0;
      low_seen_q   <= 1'b0;
      dstab_q      <= '0;
      state_q      <= S_LOW;
      hcnt_q       <= '0;
      dir_ok_q     <= 1'b0;
      strobe_q     <= 1'b0;
      step_dir_q   <= 1'b0;
      pos_q        <= '0;
      at_target_q  <= 1'b0;
      moving_q     <= 1'b0;
      idle_q       <= '0;
      dir_err_q    <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      step_sync_q  <= {step_sync_q[0], bus.step_in};
      dir_sync_q   <= {dir_sync_q[0], bus.dir_in};
      live_q       <= {live_q[0], 1'b1};
      dir_prev_q   <= s_dir;
      if (live_q[1] && !s_step) low_seen_q <= 1'b1;
      dstab_q      <= dstab_d;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      dir_ok_q     <= dir_ok_d;
      strobe_q     <= accept;
      step_dir_q   <= s_dir;
      pos_q        <= pos_d;
      at_target_q  <= (pos_q == bus.target);
      moving_q     <= moving_d;
      idle_q       <= idle_d;
      dir_err_q    <= dir_err_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
  logic limit_hit_q;
  always_ff @(posedge clock) begin
    if (reset)                 limit_hit_q <= 1'b0;
    else if (limit_set)        limit_hit_q <= 1'b1;
    else if (bus.clear_flags)  limit_hit_q <= 1'b0;
  end
  assign bus.limit_hit = limit_hit_q;
`else
  logic unused_limit;
  assign unused_limit = limit_set;
`endif

  assign bus.position    = pos_q;
  assign bus.step_strobe = strobe_q;
  assign bus.at_target   = at_target_q;
  assign bus.moving      = moving_q;
  assign bus.dir_err     = dir_err_q;
  assign bus.glitch_cnt  = glitch_cnt_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder (MIN_PULSE=4, DIR_SETUP=2, IDLE_TIMEOUT=100).
// Build with STEP_DIR_DECODER_POS_LIMIT_EN to also cover the limit clamp.
module tb_step_dir_decoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   strobe_cnt = 0;
  int   mv_run = 0;

  step_dir_decoder_if #(.POS_WIDTH(32)) bus ();

  step_dir_decoder #(
    .POS_WIDTH(32), .MIN_PULSE(4), .DIR_SETUP(2), .IDLE_TIMEOUT(100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.step_strobe) begin
      strobe_cnt++;
      mv_run = 0;
    end else if (bus.moving) begin
      mv_run++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // lat = negedge index (from the rising edge) where step_strobe was first seen, 0 if never
  task automatic pulse(input int hi, input int lo, output int lat);
    lat = 0;
    bus.step_in = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(negedge clock);
      if (bus.step_strobe && lat == 0) lat = i;
    end
    bus.step_in = 1'b0;
    for (int i = 1; i <= lo; i++) begin
      @(negedge clock);
      if (bus.step_strobe && lat == 0) lat = hi + i;
    end
  endtask

  initial begin
    int lat, base, found, waited;
    logic [31:0] exp_wrap;
    bus.step_in = 0; bus.dir_in = 0; bus.pos_load = 0; bus.pos_load_val = '0;
    bus.target = '0; bus.clear_flags = 0;
`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
    bus.lim_min = 32'h8000_0000;
    bus.lim_max = 32'h7FFF_FFFF;
`endif
    tick(3);
    check("rst_position", bus.position, 0);
    check("rst_strobe", {31'b0, bus.step_strobe}, 0);
    check("rst_at_target", {31'b0, bus.at_target}, 0);
    check("rst_moving", {31'b0, bus.moving}, 0);
    check("rst_dir_err", {31'b0, bus.dir_err}, 0);
    check("rst_glitch", {16'b0, bus.glitch_cnt}, 0);
    reset = 1'b0;
    bus.target = 32'h1234;

    // ten clean forward steps
    bus.dir_in = 1'b1;
    tick(20);
    base = strobe_cnt;
    pulse(6, 6, lat);
    check("strobe_latency", lat, 6);
    for (int i = 0; i < 9; i++) pulse(6, 6, lat);
    check("clean_position", bus.position, 10);
    check("clean_strobes", strobe_cnt - base, 10);
    check("clean_dir_err", {31'b0, bus.dir_err}, 0);
    check("clean_glitch", {16'b0, bus.glitch_cnt}, 0);

    // short pulse is rejected
    base = strobe_cnt;
    pulse(3, 6, lat);
    check("glitch_strobes", strobe_cnt - base, 0);
    check("glitch_position", bus.position, 10);
    check("glitch_cnt", {16'b0, bus.glitch_cnt}, 1);
    bus.clear_flags = 1'b1; tick(1); bus.clear_flags = 1'b0;
    check("glitch_cleared", {16'b0, bus.glitch_cnt}, 0);
    pulse(3, 6, lat);
    check("glitch_again", {16'b0, bus.glitch_cnt}, 1);
    // clear landing in the same cycle as a new glitch: increment wins
    bus.step_in = 1'b1; tick(3); bus.step_in = 1'b0; tick(2);
    bus.clear_flags = 1'b1; tick(1); bus.clear_flags = 1'b0; tick(3);
    check("glitch_clear_race", {16'b0, bus.glitch_cnt}, 1);

    // dir changed one cycle before the step edge
    bus.dir_in = 1'b0; tick(1);
    pulse(6, 6, lat);
    check("setup_position", bus.position, 9);
    check("setup_dir_err", {31'b0, bus.dir_err}, 1);
    for (int i = 0; i < 5; i++) pulse(6, 6, lat);
    check("setup_sticky_pos", bus.position, 4);
    check("setup_sticky_err", {31'b0, bus.dir_err}, 1);
    bus.clear_flags = 1'b1; tick(1); bus.clear_flags = 1'b0;
    check("dir_err_cleared", {31'b0, bus.dir_err}, 0);

    // load together with an accepted forward step
    bus.dir_in = 1'b1; tick(20);
    bus.step_in = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clock);
      if (bus.step_strobe) found = 1;
    end
    check("load_strobe_seen", found, 1);
    bus.pos_load = 1'b1; bus.pos_load_val = 32'h7FFF_FFFF;
    tick(1);
    bus.pos_load = 1'b0;
`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
    exp_wrap = 32'h7FFF_FFFF;
`else
    exp_wrap = 32'h8000_0000;
`endif
    check("load_plus_step", bus.position, exp_wrap);
    bus.target = exp_wrap;
    check("at_target_lag", {31'b0, bus.at_target}, 0);
    tick(1);
    check("at_target_hit", {31'b0, bus.at_target}, 1);
    bus.step_in = 1'b0; tick(6);

    // wrap below zero, then watch moving time out
    bus.pos_load = 1'b1; bus.pos_load_val = 32'h0; tick(1); bus.pos_load = 1'b0;
    bus.dir_in = 1'b0; tick(20);
    pulse(6, 2, lat);
    check("wrap_down", bus.position, 32'hFFFF_FFFF);
    check("moving_after_step", {31'b0, bus.moving}, 1);
    waited = 0;
    while (bus.moving && waited < 300) begin
      tick(1);
      waited++;
    end
    check("moving_timeout", {31'b0, bus.moving}, 0);
    check("moving_cycles", mv_run, 100);

    // reset while a pulse is being armed
    bus.dir_in = 1'b1;
    base = strobe_cnt;
    bus.step_in = 1'b1; tick(3);
    reset = 1'b1; tick(1);
    check("arm_rst_position", bus.position, 0);
    check("arm_rst_glitch", {16'b0, bus.glitch_cnt}, 0);
    check("arm_rst_at_target", {31'b0, bus.at_target}, 0);
    reset = 1'b0;
    tick(10); bus.step_in = 1'b0; tick(10);
    check("arm_rst_no_step", strobe_cnt - base, 0);
    check("arm_rst_pos_hold", bus.position, 0);
    check("arm_rst_no_glitch", {16'b0, bus.glitch_cnt}, 0);
    tick(10);
    pulse(6, 6, lat);
    check("post_rst_step", bus.position, 1);

`ifdef STEP_DIR_DECODER_POS_LIMIT_EN
    bus.clear_flags = 1'b1; tick(1); bus.clear_flags = 1'b0;
    check("limit_cleared", {31'b0, bus.limit_hit}, 0);
    bus.lim_max = 32'd5;
    bus.pos_load = 1'b1; bus.pos_load_val = 32'd5; tick(1); bus.pos_load = 1'b0;
    pulse(6, 6, lat);
    check("limit_position", bus.position, 5);
    check("limit_hit", {31'b0, bus.limit_hit}, 1);
    check("limit_strobe", lat, 6);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receive-side counterpart of the stepper step/dir drive path.
- Samples a step/dir pin pair, filters glitches, checks direction setup time and tracks a signed absolute position.
- Position, status and target-compare results feed regfile read ports, so the processor can read back actual motion. Position is not inferred from the commanded speed.
- One instance per axis: x and y.

Parameters:
- POS_WIDTH, 32: width of the signed position counter.
- MIN_PULSE, 4: consecutive synced-high cycles required to accept a step (must be ≥1).
- DIR_SETUP, 2: cycles dir must be stable before the step rising edge.
- IDLE_TIMEOUT, 1000000: cycles with no accepted step before moving deasserts.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- step_in  in  1  asynchronous step pin
- dir_in  in  1  asynchronous dir pin; 1 = +1 per step, 0 = −1 per step
- pos_load  in  1  one-cycle strobe: load pos_load_val
- pos_load_val  in  POS_WIDTH  position load value
- target  in  POS_WIDTH  compare value
- clear_flags  in  1  clears dir_err and glitch_cnt
- position  out  POS_WIDTH  signed position
- step_strobe  out  1  one-cycle pulse per accepted step
- at_target  out  1  registered (position == target)
- moving  out  1  step activity within IDLE_TIMEOUT
- dir_err  out  1  sticky setup violation
- glitch_cnt  out  16  saturating count of rejected pulses

Behaviour:
- Reset values: position 0, step_strobe 0, at_target 0, moving 0, dir_err 0, glitch_cnt 0, FSM in S_LOW, all counters 0, synchronizers 0.
- Reset mid-pulse discards the pulse. After reset, step_in must be seen low before a new step can be accepted.
- Input sync: step_in and dir_in each pass through a 2-flop synchronizer, giving 2 cycles latency. All logic below uses the synced signals (s_step, s_dir).
- dir stability counter: resets to 0 on any s_dir change, otherwise increments, saturating at DIR_SETUP.
- FSM state S_LOW:
  - s_step=1 → S_ARM with hcnt=1.
  - On this transition, dir_ok is latched as (stability counter ≥ DIR_SETUP).
  - If MIN_PULSE==1, go directly to S_HIGH and accept the step on this edge.
- FSM state S_ARM:
  - s_step=1 → hcnt++. When hcnt reaches MIN_PULSE, accept the step and go to S_HIGH.
  - s_step=0 before acceptance → glitch_cnt++ (saturates at 0xFFFF), go to S_LOW.
- FSM state S_HIGH: s_step=0 → S_LOW. The pulse high time is unbounded.
- Accept cycle:
  - step_strobe=1 for one cycle.
  - position updates on the next edge, using s_dir sampled at the accept cycle.
  - If dir_ok was 0, dir_err sets, and the step is still counted.
- Latency: 2 (sync) + MIN_PULSE cycles from the step_in rising edge to step_strobe; position follows 1 cycle later.
- Arithmetic: two's-complement add/subtract of 1, wrapping silently (0x7FFF_FFFF +1 → 0x8000_0000; 0 −1 → all ones).
- pos_load with a simultaneous step update: position = pos_load_val ±1. Steps are never lost.
- at_target: registered compare of the current position, so it lags position by 1 cycle.
- moving:
  - Set on the cycle after an accepted step.
  - Idle counter resets on each accepted step; moving clears when the counter reaches IDLE_TIMEOUT.
- clear_flags:
  - Clears dir_err and glitch_cnt.
  - If a new violation or glitch occurs in the same cycle, the set/increment wins: dir_err=1, glitch_cnt=1.

Optional Feature:
- Macro: STEP_DIR_DECODER_POS_LIMIT_EN.
- Defined:
  - Adds inputs lim_min and lim_max (POS_WIDTH, signed) and output limit_hit (1, sticky, cleared by clear_flags).
  - An accepted step that would move position below lim_min or above lim_max is not applied; position holds and limit_hit sets.
  - pos_load is applied unclamped.
- Undefined:
  - Those ports do not exist; positions wrap as described in Behaviour.

Test Plan:
- Ten clean pulses (high 6, low 6 cycles), dir=1 held 20 cycles beforehand → position=10, 10 step_strobe pulses, dir_err=0, glitch_cnt=0.
- 3-cycle high pulse with MIN_PULSE=4 → no step_strobe, position unchanged, glitch_cnt=1; then clear_flags → glitch_cnt=0.
- dir toggled to 0 one cycle before the step rising edge → position decrements by 1, dir_err=1 (sticky through 5 further clean steps).
- pos_load=0x7FFFFFFF with a simultaneous accepted dir=1 step → position=0x80000000; then target=0x80000000 → at_target=1 one cycle later.
- After the last step, hold step_in low with IDLE_TIMEOUT=100 → moving stays 1 for 100 cycles, then 0; reset asserted during S_ARM → all outputs 0 and no step counted.
- With STEP_DIR_DECODER_POS_LIMIT_EN, lim_max=5, position=5, one dir=1 step → position=5, limit_hit=1.
